// File: rtl/display7seg_pkg.sv
`default_nettype none
// ============================================================================
// display7seg_pkg
// Shared definitions for the multiplexed 7-segment scanner: blank segment
// pattern, hex-to-segment decoder (active-low, A = bit 6 ... G = bit 0) and
// the scan FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
package display7seg_pkg;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  typedef enum logic [0:0] {
    GUARDA = 1'b0,
    ACTIVO = 1'b1
  } estado_t;

  function automatic logic [6:0] hex_a_7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001101;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_escaneo.sv
`default_nettype none
// ============================================================================
// contador_escaneo
// Slot counter (0 .. CICLOS_SLOT-1) plus digit index (0 .. N_DIGITOS-1).
// Pulses are combinational and flag the last cycle of the guard interval,
// of the slot, and of the whole frame.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   indice_o        digit index currently scanned
//   fin_guarda_o    last guard cycle of the slot (never set if no guard)
//   fin_slot_o      last cycle of the slot
//   fin_marco_o     last cycle of the last slot of the frame
// Revision: 1.0 - initial release
// ============================================================================
module contador_escaneo #(
  parameter int N_DIGITOS     = 4,
  parameter int CICLOS_SLOT   = 50000,
  parameter int CICLOS_GUARDA = 500,
  localparam int ANCHO_IDX    = $clog2(N_DIGITOS)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ANCHO_IDX-1:0] indice_o,
  output logic                 fin_guarda_o,
  output logic                 fin_slot_o,
  output logic                 fin_marco_o
);

  localparam int ANCHO_CNT = (CICLOS_SLOT > 1) ? $clog2(CICLOS_SLOT) : 1;

  logic [ANCHO_CNT-1:0] cnt_q;
  logic [ANCHO_IDX-1:0] idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (fin_slot_o) begin
      cnt_q <= '0;
      if (idx_q == ANCHO_IDX'(N_DIGITOS - 1)) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + ANCHO_IDX'(1);
      end
    end else begin
      cnt_q <= cnt_q + ANCHO_CNT'(1);
    end
  end

  assign fin_slot_o  = (cnt_q == ANCHO_CNT'(CICLOS_SLOT - 1));
  assign fin_marco_o = fin_slot_o && (idx_q == ANCHO_IDX'(N_DIGITOS - 1));
  assign indice_o    = idx_q;

  generate
    if (CICLOS_GUARDA > 0) begin : g_con_guarda
      assign fin_guarda_o = (cnt_q == ANCHO_CNT'(CICLOS_GUARDA - 1));
    end else begin : g_sin_guarda
      assign fin_guarda_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/escaner_display_7seg.sv
`default_nettype none
// ============================================================================
// escaner_display_7seg
// Multiplexed driver for a bank of common-anode 7-segment displays. One
// active-low segment bus is time-shared across N_DIGITOS digits; each slot
// starts with an all-dark guard interval to avoid ghosting. Values are
// double-buffered (shadow on cargar, visible at frame boundary).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   binario          hex nibbles, nibble i drives digit i
//   puntos           decimal point request per digit (1 = lit)
//   cargar           strobe capturing binario/puntos into the shadow
//   habilitar        per-digit enable (0 = dark for its slot)
//   blanquear_ceros  leading-zero suppression enable
//   prenderDisplay   anodes, active-low, registered
//   ledsAhastaG      segments A..G, active-low, registered
//   DP               decimal point, active-low, registered
//   digito_activo    index of the slot being scanned, registered
// Revision: 1.0 - initial release
// ============================================================================
module escaner_display_7seg
  import display7seg_pkg::*;
#(
  parameter int N_DIGITOS     = 4,
  parameter int CICLOS_SLOT   = 50000,
  parameter int CICLOS_GUARDA = 500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4*N_DIGITOS-1:0]       binario,
  input  logic [N_DIGITOS-1:0]         puntos,
  input  logic                         cargar,
  input  logic [N_DIGITOS-1:0]         habilitar,
  input  logic                         blanquear_ceros,
  output logic [N_DIGITOS-1:0]         prenderDisplay,
  output logic [6:0]                   ledsAhastaG,
  output logic                         DP,
  output logic [$clog2(N_DIGITOS)-1:0] digito_activo
);

  localparam int ANCHO_IDX = $clog2(N_DIGITOS);
  // Without a guard interval every slot is entirely ACTIVO.
  localparam estado_t ESTADO_RESET = (CICLOS_GUARDA == 0) ? ACTIVO : GUARDA;

  logic [ANCHO_IDX-1:0] w_indice;
  logic                 w_fin_guarda;
  logic                 w_fin_slot;
  logic                 w_fin_marco;

  contador_escaneo #(
    .N_DIGITOS     (N_DIGITOS),
    .CICLOS_SLOT   (CICLOS_SLOT),
    .CICLOS_GUARDA (CICLOS_GUARDA)
  ) u_contador (
    .clk          (clk),
    .reset        (reset),
    .indice_o     (w_indice),
    .fin_guarda_o (w_fin_guarda),
    .fin_slot_o   (w_fin_slot),
    .fin_marco_o  (w_fin_marco)
  );

  estado_t                estado_q, estado_d;
  logic [4*N_DIGITOS-1:0] sombra_bin_q, vis_bin_q;
  logic [N_DIGITOS-1:0]   sombra_pts_q, vis_pts_q;
  logic [N_DIGITOS-1:0]   anodos_q, anodos_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [ANCHO_IDX-1:0]   digito_q;

  logic [3:0] w_nibble;
  logic       w_ceros_sup;
  logic       w_apagado;

  // --------------------------------------------------------------------------
  // State, buffers and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= ESTADO_RESET;
      sombra_bin_q <= '0;
      sombra_pts_q <= '0;
      vis_bin_q    <= '0;
      vis_pts_q    <= '0;
      anodos_q     <= '1;
      seg_q        <= SEG_APAGADO;
      dp_q         <= 1'b1;
      digito_q     <= '0;
    end else begin
      estado_q <= estado_d;
      if (cargar) begin
        sombra_bin_q <= binario;
        sombra_pts_q <= puntos;
      end
      // Transfer takes the pre-edge shadow, so a coincident cargar lands
      // one frame later.
      if (w_fin_marco) begin
        vis_bin_q <= sombra_bin_q;
        vis_pts_q <= sombra_pts_q;
      end
      anodos_q <= anodos_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      digito_q <= w_indice;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      GUARDA: begin
        if (w_fin_guarda) begin
          estado_d = ACTIVO;
        end
      end
      ACTIVO: begin
        if (w_fin_slot) begin
          estado_d = ESTADO_RESET;
        end
      end
      default: estado_d = ESTADO_RESET;
    endcase
  end

  // --------------------------------------------------------------------------
  // Digit selection and blanking
  // --------------------------------------------------------------------------
  always_comb begin
    w_nibble    = 4'h0;
    w_ceros_sup = 1'b1;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (w_indice == ANCHO_IDX'(i)) begin
        w_nibble = vis_bin_q[4*i +: 4];
      end
      // Leading-zero test: current digit and every more significant one.
      if ((ANCHO_IDX'(i) >= w_indice) && (vis_bin_q[4*i +: 4] != 4'h0)) begin
        w_ceros_sup = 1'b0;
      end
    end
  end

  assign w_apagado = !habilitar[w_indice] ||
                     (blanquear_ceros && (w_indice != '0) && w_ceros_sup);

  always_comb begin
    anodos_d = '1;
    seg_d    = SEG_APAGADO;
    dp_d     = 1'b1;
    if ((estado_q == ACTIVO) && !w_apagado) begin
      anodos_d[w_indice] = 1'b0;
      seg_d              = hex_a_7seg(w_nibble);
      dp_d               = ~vis_pts_q[w_indice];
    end
  end

  assign prenderDisplay = anodos_q;
  assign ledsAhastaG    = seg_q;
  assign DP             = dp_q;
  assign digito_activo  = digito_q;

endmodule
`default_nettype wire

// File: doc/escaner_display_7seg.md
# escaner_display_7seg

Parametrised multiplexed driver for common-anode 7-segment banks: time-shares one active-low segment bus across `N_DIGITOS` displays with its own scan prescaler. Adds a double-buffered value load, per-digit decimal points, per-digit enable masking, optional leading-zero blanking, and an anti-ghosting guard interval. Sits between the user datapath (hex value source) and the board pins.

## Interface
- `N_DIGITOS`, 4: number of displays; legal range ≥ 2.
- `CICLOS_SLOT`, 50000: clock cycles each digit owns per frame; must be ≥ `CICLOS_GUARDA` + 1.
- `CICLOS_GUARDA`, 500: cycles at the start of each slot with all anodes off.
- `clk`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `binario`  in  4·N_DIGITOS  hex nibbles; nibble i = bits [4i+3:4i], drives digit i.
- `puntos`  in  N_DIGITOS  decimal point request per digit, 1 = lit.
- `cargar`  in  1  one-cycle strobe; captures `binario`/`puntos` into the shadow register.
- `habilitar`  in  N_DIGITOS  per-digit enable; 0 = digit kept dark for its slot.
- `blanquear_ceros`  in  1  leading-zero suppression enable (sampled every cycle).
- `prenderDisplay`  out  N_DIGITOS  anodes, active-low, registered.
- `ledsAhastaG`  out  7  segments A (bit 6) … G (bit 0), active-low, registered.
- `DP`  out  1  decimal point, active-low, registered.
- `digito_activo`  out  clog2(N_DIGITOS)  index of the slot currently being scanned.

## Operation
- Two-stage buffering: `cargar`=1 → shadow ← {`binario`, `puntos`}. At each frame boundary (slot counter wraps, digit index N−1 → 0), visible ← shadow. A display never changes mid-frame.
- Scan FSM states: GUARDA, ACTIVO.
  - GUARDA: anodes all 1, segments 7'b1111111, DP 1; lasts `CICLOS_GUARDA` cycles, then → ACTIVO.
  - ACTIVO: lasts `CICLOS_SLOT`−`CICLOS_GUARDA` cycles, then index ← index+1 (wrap N−1 → 0) → GUARDA.
  - `CICLOS_GUARDA` = 0 skips GUARDA entirely.
- In ACTIVO for digit i, the anode bit i is 0 and all others are 1, unless digit i is blanked.
- Digit i is blanked if any of the following holds:
  - `habilitar`[i] = 0;
  - `blanquear_ceros` = 1, i ≠ 0, and visible nibbles i … N−1 are all zero.
- Digit 0 is never zero-blanked.
- A blanked digit keeps its full slot time with anodes all 1, so brightness of the other digits is unchanged.
- Segment decode uses the standard hex map: 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100, 5 → 0100100, 6 → 0100000, 7 → 0001101, 8 → 0000000, 9 → 0000100, A → 0001000, b → 1100000, C → 0110001, d → 1000010, E → 0110000, F → 0111000.
- `DP` = ~visible_puntos[i] during ACTIVO of an unblanked digit; 1 otherwise.

## Timing
- Reset (async assert): `prenderDisplay` all 1, `ledsAhastaG` 7'b1111111, `DP` 1, `digito_activo` 0, state GUARDA, slot counter 0, shadow and visible registers 0.
- After release: first slot starts with GUARDA for digit 0.
- Outputs are registered, one cycle behind FSM state; `digito_activo` is registered alongside them.
- Frame period = N_DIGITOS·`CICLOS_SLOT` cycles.
- `cargar` → visible: takes effect at the next frame boundary.
- If `cargar` coincides with the boundary edge, the transfer uses the pre-edge shadow and the new value appears one frame later.
- `cargar` held high recaptures every cycle; the last capture before a boundary wins.
- `habilitar` and `blanquear_ceros` are not buffered; changes appear on the next cycle's outputs.
- Reset mid-slot forces all outputs dark immediately. No partial slot completes.

## Structure
- Package `display7seg_pkg`:
  - constant `SEG_APAGADO` = 7'b1111111;
  - function `hex_a_7seg` (4-bit → 7-bit, map above);
  - FSM state typedef {GUARDA, ACTIVO}.
- Sub-module `contador_escaneo`: slot counter plus digit index with wrap, emits `fin_guarda`, `fin_slot`, and `fin_marco` pulses.
- Top level holds the FSM, buffers, blanking logic and output registers.

## Test plan
All scenarios use N=4, `CICLOS_SLOT`=8, `CICLOS_GUARDA`=2.
- Reset in mid-ACTIVO of digit 2 → same cycle: anodes 1111, segments 1111111, DP 1; after release, scan restarts at digit 0 GUARDA.
- `binario`=16'h1A3F, `cargar` pulse → after frame boundary, digit 0: anode 1110, segments 0111000; digit 3: anode 0111, segments 1001111; 2 dark cycles precede each.
- `binario`=16'h0005, `blanquear_ceros`=1 → digits 3, 2, 1 dark for full slots, digit 0 shows 0100100. With `binario`=16'h0000, digit 0 shows 0000001.
- `habilitar`=4'b1011, `puntos`=4'b0100 → digit 2 never lit; DP=0 only if the digit is enabled, so DP stays 1 throughout.
- `cargar` with 16'h2222 mid-frame, then 16'h7777 on the boundary cycle → next frame shows 2s, following frame shows 7s; no frame mixes values.
- Slot-length check → each anode low exactly 6 cycles per 32-cycle frame.
